// File: rtl/axi_pkg.sv
`default_nettype none
//==============================================================================
// Module   : axi_pkg
// Desc     : Shared AXI3 encodings, responder FSM state codes and helpers
// Revision : 1.0 - initial release
//==============================================================================
package axi_pkg;

    // Burst type encodings (anything other than FIXED is serviced as INCR)
    localparam logic [1:0] c_BURST_FIXED = 2'b00;
    localparam logic [1:0] c_BURST_INCR  = 2'b01;

    // Response codes
    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

    // Responder FSM state codes
    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_RD_FETCH = 3'd1;
    localparam logic [2:0] c_ST_RD_DATA  = 3'd2;
    localparam logic [2:0] c_ST_WR_DATA  = 3'd3;
    localparam logic [2:0] c_ST_WR_RESP  = 3'd4;

    // Clamp a requested beats-1 value to the largest burst we service
    function automatic logic [7:0] clamp_len(input logic [7:0] i_len,
                                             input logic [7:0] i_max_m1);
        return (i_len > i_max_m1) ? i_max_m1 : i_len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_1rw_be.sv
`default_nettype none
//==============================================================================
// Module   : sram_1rw_be
// Desc     : Single-port synchronous SRAM, 32-bit words, per-byte write enable.
//            A read is performed when enabled with no byte lanes written; the
//            output register holds its value on every other cycle.
// Revision : 1.0 - initial release
//==============================================================================
module sram_1rw_be #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic [3:0]        i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [2**ADDR_W];
    logic [31:0] r_q;

    // Byte-lane writes, or a registered read when no lane is written
    always_ff @(posedge clk) begin
        if (i_en) begin
            for (int b = 0; b < 4; b++) begin
                if (i_we[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
            if (i_we == 4'b0000) begin
                r_q <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_q;

endmodule
`default_nettype wire

// File: rtl/axi_sram_slave.sv
`default_nettype none
//==============================================================================
// Module   : axi_sram_slave
// Desc     : AXI3 responder backed by an on-chip word-addressed SRAM. Serves
//            one read or write burst at a time; read/write contention in IDLE
//            is resolved by an alternating priority bit.
// Revision : 1.0 - initial release
//==============================================================================
module axi_sram_slave
    import axi_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int MAX_LEN = 16
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam logic [7:0] c_MAX_M1 = 8'(MAX_LEN - 1);

    logic [2:0]        r_state;
    logic              r_rd_prio;
    logic [3:0]        r_id;
    logic [ADDR_W-1:0] r_idx;
    logic [7:0]        r_len;
    logic [7:0]        r_cnt;
    logic              r_fixed;
    logic              r_err;

    logic              w_idle;
    logic              w_ar_grant;
    logic              w_aw_grant;
    logic              w_w_hs;
    logic              w_r_hs;
    logic              w_last_beat;
    logic [ADDR_W-1:0] w_idx_next;
    logic              w_mem_en;
    logic [3:0]        w_mem_we;
    logic [31:0]       w_mem_q;
    logic              w_unused;

    // Size fields, write ID and the address bits outside the word index are
    // intentionally ignored (upper bits alias).
    assign w_unused = ^{arsize, awsize, wid,
                        araddr[31:ADDR_W+2], araddr[1:0],
                        awaddr[31:ADDR_W+2], awaddr[1:0]};

    assign w_idle     = (r_state == c_ST_IDLE) && !areset;
    assign w_ar_grant = w_idle && arvalid && (!awvalid || r_rd_prio);
    assign w_aw_grant = w_idle && awvalid && (!arvalid || !r_rd_prio);

    assign arready = w_ar_grant;
    assign awready = w_aw_grant;
    assign wready  = (r_state == c_ST_WR_DATA) && !areset;

    assign w_w_hs      = wready && wvalid;
    assign w_r_hs      = rvalid && rready;
    assign w_last_beat = (r_cnt == r_len);
    assign w_idx_next  = r_fixed ? r_idx : r_idx + ADDR_W'(1);

    // The SRAM is touched only in RD_FETCH or on a W beat, so its output
    // register stays frozen while an R beat is stalled.
    assign w_mem_en = (r_state == c_ST_RD_FETCH) || w_w_hs;
    assign w_mem_we = w_w_hs ? wstrb : 4'b0000;

    assign rvalid = (r_state == c_ST_RD_DATA);
    assign rdata  = rvalid ? w_mem_q : 32'h0;
    assign rlast  = rvalid && w_last_beat;
    assign rid    = r_id;
    assign rresp  = c_RESP_OKAY;

    assign bvalid = (r_state == c_ST_WR_RESP);
    assign bid    = r_id;
    assign bresp  = (bvalid && r_err) ? c_RESP_SLVERR : c_RESP_OKAY;

    sram_1rw_be #(
        .ADDR_W (ADDR_W)
    ) u_sram (
        .clk     (aclk),
        .i_en    (w_mem_en),
        .i_we    (w_mem_we),
        .i_addr  (r_idx),
        .i_wdata (wdata),
        .o_rdata (w_mem_q)
    );

    // Transaction FSM: arbitration, burst bookkeeping and response sequencing
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state   <= c_ST_IDLE;
            r_rd_prio <= 1'b0;
            r_id      <= 4'h0;
            r_idx     <= '0;
            r_len     <= 8'h0;
            r_cnt     <= 8'h0;
            r_fixed   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_ar_grant) begin
                        r_id      <= arid;
                        r_idx     <= araddr[ADDR_W+1:2];
                        r_len     <= clamp_len(arlen, c_MAX_M1);
                        r_fixed   <= (arburst == c_BURST_FIXED);
                        r_cnt     <= 8'h0;
                        r_rd_prio <= ~r_rd_prio;
                        r_state   <= c_ST_RD_FETCH;
                    end else if (w_aw_grant) begin
                        r_id      <= awid;
                        r_idx     <= awaddr[ADDR_W+1:2];
                        r_len     <= clamp_len(awlen, c_MAX_M1);
                        r_fixed   <= (awburst == c_BURST_FIXED);
                        r_cnt     <= 8'h0;
                        r_err     <= 1'b0;
                        r_rd_prio <= ~r_rd_prio;
                        r_state   <= c_ST_WR_DATA;
                    end
                end
                c_ST_RD_FETCH: begin
                    r_state <= c_ST_RD_DATA;
                end
                c_ST_RD_DATA: begin
                    if (w_r_hs) begin
                        if (w_last_beat) begin
                            r_state <= c_ST_IDLE;
                        end else begin
                            r_cnt   <= r_cnt + 8'd1;
                            r_idx   <= w_idx_next;
                            r_state <= c_ST_RD_FETCH;
                        end
                    end
                end
                c_ST_WR_DATA: begin
                    if (w_w_hs) begin
                        // A misplaced wlast only flags the error; the burst
                        // length always comes from the address phase.
                        r_err <= r_err | (wlast != w_last_beat);
                        if (w_last_beat) begin
                            r_state <= c_ST_WR_RESP;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                            r_idx <= w_idx_next;
                        end
                    end
                end
                c_ST_WR_RESP: begin
                    if (bready) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_sram_slave.sv
`default_nettype none
//==============================================================================
// Module   : tb_axi_sram_slave
// Desc     : Scoreboard bench for axi_sram_slave with directed bursts
// Revision : 1.0 - initial release
//==============================================================================
module tb_axi_sram_slave;
    import axi_pkg::*;

    localparam int TMO = 200;

    logic        aclk = 1'b0;
    logic        areset;
    logic [3:0]  arid, awid, wid, rid, bid;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb;

    wire [49:0] outs = {arready, awready, wready, rvalid, bvalid, rlast,
                        rid, bid, rdata, rresp, bresp};

    typedef struct packed { logic [3:0] id; logic [31:0] data; logic last; } r_exp_t;
    typedef struct packed { logic [3:0] id; logic [1:0] resp; } b_exp_t;

    r_exp_t rq[$];
    b_exp_t bq[$];
    int checks   = 0;
    int failures = 0;

    logic [31:0] tb_wd[16];
    logic [3:0]  tb_ws[16];
    logic        tb_wl[16];
    logic [31:0] tb_rd[16];

    logic rready_hold = 1'b0;
    int   stall_left  = 0;
    int   stall_beat  = 0;
    int   r_beat      = 0;
    logic prev_stall  = 1'b0;
    logic [36:0] prev_r = '0;

    axi_sram_slave #(.ADDR_W(12), .MAX_LEN(16)) dut (
        .aclk(aclk), .areset(areset),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial forever #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: event not seen within bound, expected it", name);
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [1:0] burst,
                            input logic [1:0] resp);
        bit ok;
        bq.push_back('{id: id, resp: resp});
        awid = id; awaddr = addr; awlen = len; awburst = burst; awsize = 3'd2;
        awvalid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < TMO && !ok; t++) begin @(negedge aclk); ok = awready; end
        if (!ok) fail_now("aw_handshake");
        @(posedge aclk); #1 awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            wdata = tb_wd[b]; wstrb = tb_ws[b]; wlast = tb_wl[b]; wvalid = 1'b1;
            ok = 1'b0;
            for (int t = 0; t < TMO && !ok; t++) begin @(negedge aclk); ok = wready; end
            if (!ok) fail_now("w_handshake");
            @(posedge aclk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        // bvalid must be up, and W closed, the cycle after the final W beat
        @(negedge aclk);
        chk("b_after_last_w", 64'({bvalid, wready}), 64'b10);
        @(posedge aclk); #1;
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [1:0] burst);
        bit ok;
        for (int b = 0; b <= int'(len); b++)
            rq.push_back('{id: id, data: tb_rd[b], last: (b == int'(len))});
        arid = id; araddr = addr; arlen = len; arburst = burst; arsize = 3'd2;
        arvalid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < TMO && !ok; t++) begin @(negedge aclk); ok = arready; end
        if (!ok) fail_now("ar_handshake");
        @(posedge aclk); #1 arvalid = 1'b0;
        @(negedge aclk); chk("r_latency_cycle1", 64'(rvalid), 64'd0);
        @(negedge aclk); chk("r_latency_cycle2", 64'(rvalid), 64'd1);
        ok = 1'b0;
        for (int t = 0; t < 4*TMO && !ok; t++) begin @(posedge aclk); ok = (rq.size() == 0); end
        if (!ok) fail_now("r_drain");
        #1;
    endtask

    // rready driver: held low on request, or stalled for a few cycles on one beat
    initial begin
        rready = 1'b1;
        forever begin
            @(posedge aclk); #1;
            if (rready_hold) rready = 1'b0;
            else if (stall_left > 0 && rvalid && r_beat == stall_beat) begin
                rready = 1'b0;
                stall_left--;
            end else rready = 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every R/B handshake, checks stall stability
    initial begin
        r_exp_t re;
        b_exp_t be;
        forever begin
            @(negedge aclk);
            if (areset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall)
                    chk("r_hold_stable", 64'({rvalid, rid, rdata, rlast}), 64'({1'b1, prev_r}));
                if (rvalid && rready) begin
                    if (rq.size() == 0) fail_now("r_unexpected_beat");
                    else begin
                        re = rq.pop_front();
                        chk("r_beat", 64'({rid, rdata, rresp, rlast}),
                            64'({re.id, re.data, c_RESP_OKAY, re.last}));
                        r_beat = re.last ? 0 : r_beat + 1;
                    end
                end
                prev_stall = rvalid && !rready;
                prev_r     = {rid, rdata, rlast};
                if (bvalid && bready) begin
                    if (bq.size() == 0) fail_now("b_unexpected");
                    else begin
                        be = bq.pop_front();
                        chk("b_resp", 64'({bid, bresp}), 64'({be.id, be.resp}));
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        bit ok;
        areset = 1'b1; bready = 1'b1;
        arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; arvalid = 0;
        awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; awvalid = 0;
        wid = 0; wdata = 0; wstrb = 0; wlast = 0; wvalid = 0;
        for (int i = 0; i < 16; i++) begin
            tb_wd[i] = 32'h0; tb_ws[i] = 4'hf; tb_wl[i] = 1'b0; tb_rd[i] = 32'h0;
        end
        repeat (3) @(posedge aclk);
        @(negedge aclk); chk("reset_outputs", 64'(outs), 64'd0);
        @(posedge aclk); #1 areset = 1'b0;
        @(negedge aclk); chk("idle_outputs", 64'(outs), 64'd0);
        @(posedge aclk); #1;

        // Arbitration right after reset: write wins first, then read
        tb_wd[0] = 32'ha5a50001; tb_wl[0] = 1'b1; tb_rd[0] = 32'ha5a50001;
        fork
            begin
                do_write(4'h1, 32'h40, 8'd0, c_BURST_INCR, c_RESP_OKAY);
                tb_wd[0] = 32'h5a5a0002;
                do_write(4'h2, 32'h40, 8'd0, c_BURST_INCR, c_RESP_OKAY);
            end
            begin
                do_read(4'h6, 32'h40, 8'd0, c_BURST_INCR);
            end
            begin
                ok = 1'b0;
                for (int t = 0; t < TMO && !ok; t++) begin @(negedge aclk); ok = arvalid && awvalid; end
                if (!ok) fail_now("arb_first_contention");
                else chk("arb_first_grant_write", 64'({arready, awready}), 64'b01);
                ok = 1'b0;
                for (int t = 0; t < TMO && !ok; t++) begin @(negedge aclk); ok = arvalid && awvalid; end
                if (!ok) fail_now("arb_second_contention");
                else chk("arb_second_grant_read", 64'({arready, awready}), 64'b10);
            end
        join
        tb_rd[0] = 32'h5a5a0002;
        do_read(4'h7, 32'h40, 8'd0, c_BURST_INCR);

        // Single write then read, upper address bits aliased away
        tb_wd[0] = 32'hdeadbeef; tb_rd[0] = 32'hdeadbeef;
        do_write(4'h3, 32'h1fc00010, 8'd0, c_BURST_INCR, c_RESP_OKAY);
        do_read(4'h5, 32'h1fc00010, 8'd0, c_BURST_INCR);

        // INCR burst, second read beat stalled for three cycles
        tb_wd[0] = 32'h11; tb_wd[1] = 32'h22; tb_wd[2] = 32'h33; tb_wd[3] = 32'h44;
        tb_wl[0] = 0; tb_wl[1] = 0; tb_wl[2] = 0; tb_wl[3] = 1;
        do_write(4'h1, 32'h100, 8'd3, c_BURST_INCR, c_RESP_OKAY);
        tb_rd[0] = 32'h11; tb_rd[1] = 32'h22; tb_rd[2] = 32'h33; tb_rd[3] = 32'h44;
        stall_beat = 1; stall_left = 3;
        do_read(4'h2, 32'h100, 8'd3, c_BURST_INCR);

        // Byte strobes
        tb_wd[0] = 32'hffffffff; tb_wl[0] = 1'b1;
        do_write(4'h4, 32'h20, 8'd0, c_BURST_INCR, c_RESP_OKAY);
        tb_wd[0] = 32'h12345678; tb_ws[0] = 4'b0101;
        do_write(4'h4, 32'h20, 8'd0, c_BURST_INCR, c_RESP_OKAY);
        tb_ws[0] = 4'hf;
        tb_rd[0] = 32'hff34ff78;
        do_read(4'h4, 32'h20, 8'd0, c_BURST_INCR);

        // FIXED burst leaves only the final value; the next word is untouched
        tb_wd[0] = 32'h5555aaaa;
        do_write(4'h8, 32'h34, 8'd0, c_BURST_INCR, c_RESP_OKAY);
        tb_wd[0] = 32'h01010101; tb_wd[1] = 32'h02020202; tb_wd[2] = 32'h03030303;
        tb_wl[0] = 0; tb_wl[1] = 0; tb_wl[2] = 1;
        do_write(4'h8, 32'h30, 8'd2, c_BURST_FIXED, c_RESP_OKAY);
        tb_rd[0] = 32'h03030303; tb_rd[1] = 32'h5555aaaa;
        do_read(4'h8, 32'h30, 8'd1, c_BURST_INCR);

        // Early wlast: all three beats still taken, SLVERR; then a clean write
        tb_wd[0] = 32'he0; tb_wd[1] = 32'he1; tb_wd[2] = 32'he2;
        tb_wl[0] = 0; tb_wl[1] = 1; tb_wl[2] = 0;
        do_write(4'ha, 32'h200, 8'd2, c_BURST_INCR, c_RESP_SLVERR);
        tb_wl[0] = 0; tb_wl[1] = 0; tb_wl[2] = 1;
        do_write(4'hb, 32'h200, 8'd2, c_BURST_INCR, c_RESP_OKAY);

        // Reset during RD_DATA of a 4-beat read abandons it silently
        rready_hold = 1'b1;
        arid = 4'hc; araddr = 32'h100; arlen = 8'd3; arburst = c_BURST_INCR; arvalid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < TMO && !ok; t++) begin @(negedge aclk); ok = arready; end
        if (!ok) fail_now("rst_ar_handshake");
        @(posedge aclk); #1 arvalid = 1'b0;
        ok = 1'b0;
        for (int t = 0; t < TMO && !ok; t++) begin @(negedge aclk); ok = rvalid; end
        if (!ok) fail_now("rst_rvalid_wait");
        @(posedge aclk); #1 areset = 1'b1;
        @(posedge aclk); #1 areset = 1'b0;
        @(negedge aclk); chk("rst_mid_burst_outputs", 64'(outs), 64'd0);
        rready_hold = 1'b0;
        @(posedge aclk); #1;
        tb_rd[0] = 32'h11; tb_rd[1] = 32'h22; tb_rd[2] = 32'h33; tb_rd[3] = 32'h44;
        do_read(4'h9, 32'h100, 8'd3, c_BURST_INCR);

        repeat (5) @(posedge aclk);
        chk("scoreboard_empty", 64'(rq.size() + bq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
